// File: rtl/regfile_mp_sb_if.sv
// Register file bus: decode-side reads and busy checks, writeback ports A/B and scoreboard set.
// The master drives addresses and writes; the slave (the register file) returns data and status.
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wa_en;
  logic [AW-1:0]   wa_addr;
  logic [XLEN-1:0] wa_data;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic            sb_dup;

  modport master (
    output rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, sb_set, sb_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, sb_dup
  );

  modport slave (
    input  rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, sb_set, sb_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, sb_dup
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Integer register file with two read ports, two write ports (A: execute, B: load)
// and a per-register pending-load scoreboard; x0 reads as zero and is never busy.
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  regfile_mp_sb_if.slave bus
);
  localparam int   AW        = $clog2(NREGS);
  localparam logic BYPASS_ON = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             dup_next;
  logic             wa_hit_nz;
  logic             wb_store;

  assign wa_hit_nz = bus.wa_en && (bus.wa_addr != '0);
  // Port A owns a colliding write; port B only stores when it does not collide.
  assign wb_store  = bus.wb_en && (bus.wb_addr != '0)
                     && !(bus.wa_en && (bus.wa_addr == bus.wb_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wa_hit_nz) regs[bus.wa_addr] <= bus.wa_data;
      if (wb_store)  regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Clear from the retiring load first so a new load to the same register wins.
  always_comb begin
    busy_next = busy;
    if (bus.wb_en)  busy_next[bus.wb_addr] = 1'b0;
    if (bus.sb_set) busy_next[bus.sb_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign dup_next = bus.sb_set && (bus.sb_addr != '0) && busy[bus.sb_addr]
                    && !(bus.wb_en && (bus.wb_addr == bus.sb_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      bus.sb_dup <= 1'b0;
    end else begin
      busy       <= busy_next;
      bus.sb_dup <= dup_next;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = regs[addr];
    if (BYPASS_ON) begin
      if (bus.wb_en && (bus.wb_addr == addr)) val = bus.wb_data;
      if (bus.wa_en && (bus.wa_addr == addr)) val = bus.wa_data;
    end
    if (addr == '0) val = '0;
    return val;
  endfunction

  // A register being filled by port B this cycle is not busy, unless a new load re-marks it.
  function automatic logic busy_port(input logic [AW-1:0] addr);
    logic fwd;
    fwd = BYPASS_ON && bus.wb_en && (bus.wb_addr == addr)
          && !(bus.sb_set && (bus.sb_addr == addr));
    return busy[addr] && !fwd;
  endfunction

  always_comb begin
    bus.rs1_data = read_port(bus.rs1_addr);
    bus.rs2_data = read_port(bus.rs2_addr);
    bus.rs1_busy = busy_port(bus.rs1_addr);
    bus.rs2_busy = busy_port(bus.rs2_addr);
  end
endmodule
